// File: rtl/fetch_coverage_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_cov_pkg
//  Purpose  : Shared types and constants for the fetch coverage collector:
//             fixed bin enumeration, bin-count helper, readout response.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_cov_pkg;

    localparam int NUM_FIXED_BINS = 8;
    localparam int MAX_CNT_W      = 32;

    typedef enum logic [2:0] {
        BIN_SEQ_FETCH      = 3'd0,
        BIN_BR_TAKEN       = 3'd1,
        BIN_BR_NOT_TAKEN   = 3'd2,
        BIN_PRED_CORRECT   = 3'd3,
        BIN_PRED_INCORRECT = 3'd4,
        BIN_BUF_FULL       = 3'd5,
        BIN_BUF_EMPTY      = 3'd6,
        BIN_STALL          = 3'd7
    } cov_bin_e;

    // Total bin count: fixed bins, one per PC region, plus the optional
    // transition bins.
    function automatic int num_bins(input int pc_regions);
`ifdef FETCH_COV_TRANSITION_EN
        return NUM_FIXED_BINS + pc_regions + 2;
`else
        return NUM_FIXED_BINS + pc_regions;
`endif
    endfunction

    // Count is held at the widest supported counter width; the top truncates.
    typedef struct packed {
        logic                 valid;
        logic [MAX_CNT_W-1:0] count;
        logic                 covered;
        logic                 err;
    } rd_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fetch_coverage_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_coverage_collector_if
//  Purpose  : Observation and readout bus of the fetch coverage collector.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_coverage_collector_if #(
    parameter int CNT_W    = 16,
    parameter int NUM_BINS = 12
) ();
    logic [31:0]         pc;
    logic                instruction_valid;
    logic                prediction_valid;
    logic                prediction;
    logic                branch_resolved;
    logic                branch_taken;
    logic                prefetch_full;
    logic                prefetch_empty;
    logic                stall;
    logic                flush;
    logic                clear;
    logic                rd_en;
    logic [7:0]          rd_idx;
    logic                rd_valid;
    logic [CNT_W-1:0]    rd_count;
    logic                rd_covered;
    logic                rd_err;
    logic [NUM_BINS-1:0] covered_mask;
    logic [7:0]          covered_total;
    logic                all_covered;
    logic                orphan_err;
    logic                overflow_err;

    modport master (
        output pc, instruction_valid, prediction_valid, prediction,
               branch_resolved, branch_taken, prefetch_full, prefetch_empty,
               stall, flush, clear, rd_en, rd_idx,
        input  rd_valid, rd_count, rd_covered, rd_err, covered_mask,
               covered_total, all_covered, orphan_err, overflow_err
    );

    modport slave (
        input  pc, instruction_valid, prediction_valid, prediction,
               branch_resolved, branch_taken, prefetch_full, prefetch_empty,
               stall, flush, clear, rd_en, rd_idx,
        output rd_valid, rd_count, rd_covered, rd_err, covered_mask,
               covered_total, all_covered, orphan_err, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_coverage_collector_pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cov_pred_fifo
//  Purpose  : DEPTH x 1-bit in-order prediction FIFO. Matches the oldest
//             prediction to a branch resolution, bypasses when empty, and
//             flags orphan resolutions and overflowing pushes.
//  Revision : 1.0  initial release
// ============================================================================
module cov_pred_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic push_i,
    input  wire logic data_i,
    input  wire logic pop_i,
    input  wire logic flush_i,
    output logic      match_o,
    output logic      match_data_o,
    output logic      orphan_o,
    output logic      overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_empty, w_full, w_do_push, w_do_pop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == FULL_CNT);

    // Decide this cycle's match/push/pop; flush overrides everything.
    always_comb begin
        match_o      = 1'b0;
        match_data_o = 1'b0;
        orphan_o     = 1'b0;
        overflow_o   = 1'b0;
        w_do_push    = 1'b0;
        w_do_pop     = 1'b0;
        if (!flush_i) begin
            if (pop_i) begin
                if (!w_empty) begin
                    match_o      = 1'b1;
                    match_data_o = mem_q[rd_ptr_q];
                    w_do_pop     = 1'b1;
                    w_do_push    = push_i;
                end else if (push_i) begin
                    match_o      = 1'b1;
                    match_data_o = data_i;
                end else begin
                    orphan_o = 1'b1;
                end
            end else if (push_i) begin
                if (w_full) overflow_o = 1'b1;
                else        w_do_push  = 1'b1;
            end
        end
    end

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W + 1)'(w_do_push) - (PTR_W + 1)'(w_do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Prediction storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_coverage_collector.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_coverage_collector
//  Purpose  : Functional coverage collector for the fetch unit: saturating
//             per-bin hit counters, GOAL-based covered flags, prediction
//             scoring, PC-region bins and a registered readout port.
//  Config   : FETCH_COV_TRANSITION_EN adds FULL_TO_EMPTY and MISPRED_B2B bins.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_coverage_collector
    import fetch_cov_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int GOAL       = 4,
    parameter int PRED_DEPTH = 4,
    parameter int PC_REGIONS = 4,
    parameter int REGION_LSB = 12
) (
    input wire logic                  clk,
    input wire logic                  rst,
    fetch_coverage_collector_if.slave bus
);
    localparam int NUM_BINS = num_bins(PC_REGIONS);
    localparam int RIDX_W   = (PC_REGIONS > 1) ? $clog2(PC_REGIONS) : 1;
    localparam int REG_BASE = NUM_FIXED_BINS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] GOAL_C  = CNT_W'(GOAL);

    logic w_match, w_match_pred, w_orphan_evt, w_overflow_evt;
    logic w_pred_correct, w_pred_incorrect;
    logic [RIDX_W-1:0]   w_region;
    logic [NUM_BINS-1:0] w_hit;
    logic [NUM_BINS-1:0] w_cov;
    logic [CNT_W-1:0]    w_cnt [NUM_BINS];
    logic [7:0]          w_cov_total;

    cov_pred_fifo #(.DEPTH(PRED_DEPTH)) u_pred_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (bus.prediction_valid),
        .data_i       (bus.prediction),
        .pop_i        (bus.branch_resolved),
        .flush_i      (bus.flush),
        .match_o      (w_match),
        .match_data_o (w_match_pred),
        .orphan_o     (w_orphan_evt),
        .overflow_o   (w_overflow_evt)
    );

    assign w_region         = bus.pc[REGION_LSB +: RIDX_W];
    assign w_pred_correct   = w_match && (w_match_pred == bus.branch_taken);
    assign w_pred_incorrect = w_match && (w_match_pred != bus.branch_taken);

    assign w_hit[int'(BIN_SEQ_FETCH)]      = bus.instruction_valid && !bus.branch_resolved;
    assign w_hit[int'(BIN_BR_TAKEN)]       = bus.branch_resolved && bus.branch_taken;
    assign w_hit[int'(BIN_BR_NOT_TAKEN)]   = bus.branch_resolved && !bus.branch_taken;
    assign w_hit[int'(BIN_PRED_CORRECT)]   = w_pred_correct;
    assign w_hit[int'(BIN_PRED_INCORRECT)] = w_pred_incorrect;
    assign w_hit[int'(BIN_BUF_FULL)]       = bus.prefetch_full;
    assign w_hit[int'(BIN_BUF_EMPTY)]      = bus.prefetch_empty;
    assign w_hit[int'(BIN_STALL)]          = bus.stall;

    generate
        for (genvar r = 0; r < PC_REGIONS; r++) begin : g_region
            assign w_hit[REG_BASE + r] = bus.instruction_valid && (w_region == RIDX_W'(r));
        end
    endgenerate

`ifdef FETCH_COV_TRANSITION_EN
    logic prev_full_q, prev_full_d;
    logic last_incorrect_q, last_incorrect_d;

    // History for transition bins: full flag of the last sampled cycle and
    // whether the last matched resolution was a misprediction.
    always_comb begin
        prev_full_d      = prev_full_q;
        last_incorrect_d = last_incorrect_q;
        if (!bus.clear) prev_full_d = bus.prefetch_full;
        if (bus.flush)    last_incorrect_d = 1'b0;
        else if (w_match) last_incorrect_d = w_pred_incorrect;
    end

    // History registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_full_q      <= 1'b0;
            last_incorrect_q <= 1'b0;
        end else begin
            prev_full_q      <= prev_full_d;
            last_incorrect_q <= last_incorrect_d;
        end
    end

    assign w_hit[REG_BASE + PC_REGIONS]     = bus.prefetch_empty && prev_full_q;
    assign w_hit[REG_BASE + PC_REGIONS + 1] = w_pred_incorrect && last_incorrect_q;
`endif

    generate
        for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturating increment; clear wins over a hit.
            always_comb begin
                cnt_d = cnt_q;
                if (bus.clear)                       cnt_d = '0;
                else if (w_hit[b] && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end

            // Hit counter register.
            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign w_cnt[b] = cnt_q;
            assign w_cov[b] = (cnt_q >= GOAL_C);
        end
    endgenerate

    // Number of bins currently at or above GOAL.
    always_comb begin
        w_cov_total = '0;
        for (int b = 0; b < NUM_BINS; b++) w_cov_total = w_cov_total + 8'(w_cov[b]);
    end

    logic [NUM_BINS-1:0] covered_mask_q;
    logic [7:0]          covered_total_q;
    logic                all_covered_q;

    // Covered summary, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            covered_mask_q  <= '0;
            covered_total_q <= '0;
            all_covered_q   <= 1'b0;
        end else begin
            covered_mask_q  <= w_cov;
            covered_total_q <= w_cov_total;
            all_covered_q   <= &w_cov;
        end
    end

    rd_rsp_t rsp_d, rsp_q;

    // Readout mux over the pre-update counter values.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = bus.rd_en;
        if (bus.rd_en) begin
            if (int'({24'd0, bus.rd_idx}) >= NUM_BINS) begin
                rsp_d.err = 1'b1;
            end else begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    if (bus.rd_idx == 8'(b)) begin
                        rsp_d.count   = MAX_CNT_W'(w_cnt[b]);
                        rsp_d.covered = w_cov[b];
                    end
                end
            end
        end
    end

    // Readout response register; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (rst) rsp_q <= '0;
        else     rsp_q <= rsp_d;
    end

    generate
        if (CNT_W < MAX_CNT_W) begin : g_rsp_hi
            logic w_unused_rsp_hi;
            assign w_unused_rsp_hi = |rsp_q.count[MAX_CNT_W-1:CNT_W];
        end
    endgenerate

    logic orphan_q, orphan_d, overflow_q, overflow_d;

    // Sticky FIFO error flags; clear wins over a new event.
    always_comb begin
        orphan_d   = orphan_q | w_orphan_evt;
        overflow_d = overflow_q | w_overflow_evt;
        if (bus.clear) begin
            orphan_d   = 1'b0;
            overflow_d = 1'b0;
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            orphan_q   <= orphan_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.rd_valid      = rsp_q.valid;
    assign bus.rd_count      = rsp_q.count[CNT_W-1:0];
    assign bus.rd_covered    = rsp_q.covered;
    assign bus.rd_err        = rsp_q.err;
    assign bus.covered_mask  = covered_mask_q;
    assign bus.covered_total = covered_total_q;
    assign bus.all_covered   = all_covered_q;
    assign bus.orphan_err    = orphan_q;
    assign bus.overflow_err  = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_coverage_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_coverage_collector
//  Purpose  : Self-checking bench for fetch_coverage_collector: directed
//             scenarios followed by random traffic against a queue-based
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_coverage_collector;
    import fetch_cov_pkg::*;

    localparam int CNT_W   = 4;
    localparam int GOAL    = 4;
    localparam int DEPTH   = 4;
    localparam int REGIONS = 4;
    localparam int RLSB    = 12;
    localparam int NB      = num_bins(REGIONS);
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_coverage_collector_if #(.CNT_W(CNT_W), .NUM_BINS(NB)) bus ();

    fetch_coverage_collector #(
        .CNT_W(CNT_W), .GOAL(GOAL), .PRED_DEPTH(DEPTH),
        .PC_REGIONS(REGIONS), .REGION_LSB(RLSB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cnt [NB];
    bit m_q [$];
    bit m_orphan, m_overflow;

    // Expected outputs for the upcoming edge
    bit          e_rd_valid, e_rd_cov, e_rd_err;
    int          e_rd_count;
    logic [NB-1:0] e_mask;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit hit [NB];
        bit matched, mp, orph, ovf;
        int idx, r;
        idx        = int'(bus.rd_idx);
        e_rd_valid = !rst && bus.rd_en;
        e_rd_err   = idx >= NB;
        e_rd_count = e_rd_err ? 0 : m_cnt[idx];
        e_rd_cov   = !e_rd_err && (m_cnt[idx] >= GOAL);
        for (int b = 0; b < NB; b++) e_mask[b] = !rst && (m_cnt[b] >= GOAL);

        if (rst) begin
            for (int b = 0; b < NB; b++) m_cnt[b] = 0;
            m_q.delete();
            m_orphan   = 0;
            m_overflow = 0;
        end else begin
            matched = 0; mp = 0; orph = 0; ovf = 0;
            if (bus.flush) begin
                m_q.delete();
            end else if (bus.branch_resolved) begin
                if (m_q.size() > 0) begin
                    matched = 1;
                    mp = m_q.pop_front();
                    if (bus.prediction_valid) m_q.push_back(bus.prediction);
                end else if (bus.prediction_valid) begin
                    matched = 1;
                    mp = bus.prediction;
                end else begin
                    orph = 1;
                end
            end else if (bus.prediction_valid) begin
                if (m_q.size() == DEPTH) ovf = 1;
                else m_q.push_back(bus.prediction);
            end

            for (int b = 0; b < NB; b++) hit[b] = 0;
            hit[0] = bus.instruction_valid && !bus.branch_resolved;
            hit[1] = bus.branch_resolved && bus.branch_taken;
            hit[2] = bus.branch_resolved && !bus.branch_taken;
            hit[3] = matched && (mp == bus.branch_taken);
            hit[4] = matched && (mp != bus.branch_taken);
            hit[5] = bus.prefetch_full;
            hit[6] = bus.prefetch_empty;
            hit[7] = bus.stall;
            r = int'((bus.pc >> RLSB) % REGIONS);
            hit[NUM_FIXED_BINS + r] = bus.instruction_valid;

            if (bus.clear) begin
                for (int b = 0; b < NB; b++) m_cnt[b] = 0;
                m_orphan   = 0;
                m_overflow = 0;
            end else begin
                for (int b = 0; b < NB; b++)
                    if (hit[b] && m_cnt[b] < SAT) m_cnt[b]++;
                m_orphan   = m_orphan | orph;
                m_overflow = m_overflow | ovf;
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("rd_valid", bus.rd_valid, e_rd_valid);
        if (e_rd_valid) begin
            check_eq("rd_count", bus.rd_count, e_rd_count);
            check_eq("rd_covered", bus.rd_covered, e_rd_cov);
            check_eq("rd_err", bus.rd_err, e_rd_err);
        end
        check_eq("covered_mask", bus.covered_mask, e_mask);
        check_eq("covered_total", bus.covered_total, $countones(e_mask));
        check_eq("all_covered", bus.all_covered, &e_mask);
        check_eq("orphan_err", bus.orphan_err, m_orphan);
        check_eq("overflow_err", bus.overflow_err, m_overflow);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        bus.pc                = '0;
        bus.instruction_valid = 0;
        bus.prediction_valid  = 0;
        bus.prediction        = 0;
        bus.branch_resolved   = 0;
        bus.branch_taken      = 0;
        bus.prefetch_full     = 0;
        bus.prefetch_empty    = 0;
        bus.stall             = 0;
        bus.flush             = 0;
        bus.clear             = 0;
        bus.rd_en             = 0;
        bus.rd_idx            = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic read_bin(input int idx, input int exp);
        idle();
        bus.rd_en  = 1;
        bus.rd_idx = 8'(idx);
        cycle();
        check_eq($sformatf("read_bin%0d", idx), bus.rd_count, exp);
        bus.rd_en = 0;
    endtask

    initial begin
        // 1: reset with every input high
        rst = 1;
        bus.pc = '1;
        bus.instruction_valid = 1; bus.prediction_valid = 1; bus.prediction = 1;
        bus.branch_resolved = 1; bus.branch_taken = 1; bus.prefetch_full = 1;
        bus.prefetch_empty = 1; bus.stall = 1; bus.flush = 1; bus.clear = 1;
        bus.rd_en = 1; bus.rd_idx = '1;
        repeat (2) cycle();
        rst = 0;
        idle();
        check_eq("rst_mask", bus.covered_mask, 0);
        check_eq("rst_orphan", bus.orphan_err, 0);
        check_eq("rst_rd_valid", bus.rd_valid, 0);
        for (int i = 0; i < NB; i++) read_bin(i, 0);

        // 2: GOAL threshold on the stall bin
        repeat (3) begin
            idle(); bus.stall = 1; cycle();
            idle(); cycle();
        end
        check_eq("stall_3_uncov", bus.covered_mask[7], 0);
        idle(); bus.stall = 1; cycle();
        check_eq("stall_4_lag", bus.covered_mask[7], 0);
        idle(); cycle();
        check_eq("stall_4_cov", bus.covered_mask[7], 1);
        read_bin(7, 4);

        // 3: in-order prediction scoring
        do_reset();
        idle(); bus.prediction_valid = 1; bus.prediction = 1; cycle();
        bus.prediction = 0; cycle();
        bus.prediction = 1; cycle();
        idle(); bus.branch_resolved = 1; bus.branch_taken = 1;
        repeat (3) cycle();
        read_bin(3, 2);
        read_bin(4, 1);
        read_bin(1, 3);

        // 4: bypass on empty FIFO, then an orphan resolution
        do_reset();
        idle(); bus.prediction_valid = 1; bus.prediction = 0;
        bus.branch_resolved = 1; bus.branch_taken = 0; cycle();
        idle(); cycle();
        check_eq("bypass_no_orphan", bus.orphan_err, 0);
        read_bin(3, 1);
        idle(); bus.branch_resolved = 1; cycle();
        check_eq("lone_resolve_orphan", bus.orphan_err, 1);

        // 5: overflow keeps DEPTH entries; flush then resolve is an orphan
        do_reset();
        idle(); bus.prediction_valid = 1; bus.prediction = 1;
        repeat (5) cycle();
        check_eq("overflow_set", bus.overflow_err, 1);
        idle(); bus.branch_resolved = 1; bus.branch_taken = 1;
        repeat (4) cycle();
        check_eq("four_kept_no_orphan", bus.orphan_err, 0);
        read_bin(3, 4);
        idle(); bus.prediction_valid = 1; cycle();
        idle(); bus.flush = 1; cycle();
        idle(); bus.branch_resolved = 1; cycle();
        check_eq("flush_orphan", bus.orphan_err, 1);

        // 6: region bin saturation and clear/readout ordering
        do_reset();
        idle(); bus.instruction_valid = 1; bus.pc = 32'h0000_3000;
        repeat (20) cycle();
        read_bin(11, 15);
        idle(); bus.clear = 1; bus.rd_en = 1; bus.rd_idx = 8'd11; cycle();
        check_eq("clear_read_pre", bus.rd_count, 15);
        read_bin(11, 0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst                   = ($urandom % 300) == 0;
            bus.clear             = ($urandom % 80) == 0;
            bus.flush             = ($urandom % 16) == 0;
            bus.prediction_valid  = ($urandom % 3) == 0;
            bus.prediction        = 1'($urandom);
            bus.branch_resolved   = ($urandom % 3) == 0;
            bus.branch_taken      = 1'($urandom);
            bus.prefetch_full     = ($urandom % 4) == 0;
            bus.prefetch_empty    = ($urandom % 4) == 0;
            bus.stall             = ($urandom % 4) == 0;
            bus.instruction_valid = 1'($urandom);
            bus.pc                = $urandom;
            bus.rd_en             = 1'($urandom);
            bus.rd_idx            = 8'($urandom % (NB + 4));
            cycle();
        end
        rst = 0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
